axi_user_mem: RTL and testbench

Word-addressed memory responder for the single-initiator AXI user interface driven by the data-cache refill/writeback path. It accepts one transaction per `axi_start` pulse and returns read bursts beat by beat with a fixed configurable latency. It absorbs write bursts under `wvalid`/`wready` handshake and signals completion with `axi_done`. It stands in for the external memory side in simulation and on FPGA, so the cache and MEM stage run unchanged.

---
 rtl/axi_user_mem_if.sv | 25 ++
 rtl/axi_user_mem.sv | 138 +++++++++++++
 tb/tb_axi_user_mem.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_user_mem_if.sv
// Single-initiator AXI user bus between the data-cache refill/writeback path and memory.
// The master drives the request and write beats; the slave returns read beats and status.
interface axi_user_mem_if;
  logic        axi_start;
  logic        axi_rw;
  logic [31:0] axi_addr;
  logic [7:0]  axi_len;
  logic [31:0] axi_wdata;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        axi_done;
  logic        axi_busy;

  modport master (
    output axi_start, axi_rw, axi_addr, axi_len, axi_wdata, axi_wvalid,
    input  axi_wready, axi_rdata, axi_rvalid, axi_done, axi_busy
  );

  modport slave (
    input  axi_start, axi_rw, axi_addr, axi_len, axi_wdata, axi_wvalid,
    output axi_wready, axi_rdata, axi_rvalid, axi_done, axi_busy
  );
endinterface

// File: rtl/axi_user_mem.sv
// Word-addressed burst memory responder; first read beat READ_LAT+1 cycles after start.
// Reads have no back-pressure; writes stall on wvalid=0 with wready held high.
module axi_user_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_BITS = 10,
  parameter int READ_LAT  = 2
) (
  input  logic           clk,
  input  logic           resetn,
  axi_user_mem_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   idx;
  logic [7:0]             beats_left;
  logic [3:0]             lat_cnt;
  logic                   wready_q;
  logic                   rvalid_q;
  logic [31:0]            rdata_q;
  logic                   done_q;
  logic                   busy_q;

  logic [31:0]            mem [MEM_WORDS];

  logic [ADDR_BITS-1:0]   start_idx;
  logic                   wr_fire;
  logic                   unused_addr_bits;

  assign start_idx        = bus.axi_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{bus.axi_addr[31:ADDR_BITS+2], bus.axi_addr[1:0]};
  assign wr_fire          = (state == WR_BURST) && bus.axi_wvalid;

  // Storage is deliberately outside the reset domain: contents survive resetn.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[idx] <= bus.axi_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= '0;
      beats_left <= '0;
      lat_cnt    <= '0;
      wready_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.axi_start) begin
            beats_left <= bus.axi_len;
            busy_q     <= 1'b1;
            if (!bus.axi_rw) begin
              state    <= WR_BURST;
              idx      <= start_idx;
              wready_q <= 1'b1;
            end else if (READ_LAT == 0) begin
              state    <= RD_BURST;
              rvalid_q <= 1'b1;
              rdata_q  <= mem[start_idx];
              idx      <= start_idx + 1'b1;
            end else begin
              state    <= RD_WAIT;
              idx      <= start_idx;
              lat_cnt  <= 4'(READ_LAT - 1);
            end
          end
        end

        RD_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state    <= RD_BURST;
            rvalid_q <= 1'b1;
            rdata_q  <= mem[idx];
            idx      <= idx + 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        // rvalid marks the beat currently on the bus; beats_left counts those still to come.
        RD_BURST: begin
          if (beats_left == 8'd0) begin
            state    <= DONE;
            rvalid_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            rdata_q    <= mem[idx];
            idx        <= idx + 1'b1;
            beats_left <= beats_left - 8'd1;
          end
        end

        WR_BURST: begin
          if (bus.axi_wvalid) begin
            idx <= idx + 1'b1;
            if (beats_left == 8'd0) begin
              state    <= DONE;
              wready_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              beats_left <= beats_left - 8'd1;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.axi_wready = wready_q;
  assign bus.axi_rvalid = rvalid_q;
  assign bus.axi_rdata  = rdata_q;
  assign bus.axi_done   = done_q;
  assign bus.axi_busy   = busy_q;

endmodule

// File: tb/tb_axi_user_mem.sv
// Bench for axi_user_mem: three instances (READ_LAT 2, 0, 5) share one request stream,
// a transaction table drives the main traffic, hand sequences cover ignored start and reset.
module tb_axi_user_mem;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        rw;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [31:0] wdata;
  logic        wvalid;
  logic        all_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_user_mem_if m0 ();
  axi_user_mem_if m1 ();
  axi_user_mem_if m2 ();

  // Instances 1 and 2 only see a start while all_en is set.
  assign m0.axi_start  = start;
  assign m1.axi_start  = start & all_en;
  assign m2.axi_start  = start & all_en;
  assign m0.axi_rw     = rw;
  assign m1.axi_rw     = rw;
  assign m2.axi_rw     = rw;
  assign m0.axi_addr   = addr;
  assign m1.axi_addr   = addr;
  assign m2.axi_addr   = addr;
  assign m0.axi_len    = len;
  assign m1.axi_len    = len;
  assign m2.axi_len    = len;
  assign m0.axi_wdata  = wdata;
  assign m1.axi_wdata  = wdata;
  assign m2.axi_wdata  = wdata;
  assign m0.axi_wvalid = wvalid;
  assign m1.axi_wvalid = wvalid;
  assign m2.axi_wvalid = wvalid;

  axi_user_mem #(.MEM_WORDS(1024), .ADDR_BITS(10), .READ_LAT(2)) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(m0)
  );
  axi_user_mem #(.MEM_WORDS(1024), .ADDR_BITS(10), .READ_LAT(0)) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(m1)
  );
  axi_user_mem #(.MEM_WORDS(1024), .ADDR_BITS(10), .READ_LAT(5)) u_dut2 (
    .clk(clk), .resetn(resetn), .bus(m2)
  );

  logic        rv [3];
  logic [31:0] rd [3];
  logic        dn [3];
  logic        bz [3];
  logic        wr [3];

  assign rv[0] = m0.axi_rvalid;  assign rv[1] = m1.axi_rvalid;  assign rv[2] = m2.axi_rvalid;
  assign rd[0] = m0.axi_rdata;   assign rd[1] = m1.axi_rdata;   assign rd[2] = m2.axi_rdata;
  assign dn[0] = m0.axi_done;    assign dn[1] = m1.axi_done;    assign dn[2] = m2.axi_done;
  assign bz[0] = m0.axi_busy;    assign bz[1] = m1.axi_busy;    assign bz[2] = m2.axi_busy;
  assign wr[0] = m0.axi_wready;  assign wr[1] = m1.axi_wready;  assign wr[2] = m2.axi_wready;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  len;
    int          stall_after;
    int          stall_n;
    logic [31:0] base;
    logic [31:0] step;
  } vec_t;

  vec_t vecs [8];

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 5;
    endcase
  endfunction

  function automatic int n_duts();
    return all_en ? 3 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Entered and left just after a rising edge with every instance idle.
  task automatic run_write(input logic [31:0] a, input logic [7:0] l, input logic [31:0] d [8],
                           input int stall_after, input int stall_n, input string tag);
    int wr_low [3] = '{0, 0, 0};
    start = 1'b1; rw = 1'b0; addr = a; len = l;
    @(posedge clk); #1;
    start = 1'b0; rw = 1'b1; addr = 32'hFFFF_FFFC; len = 8'hFF;
    for (int i = 0; i <= int'(l); i++) begin
      wvalid = 1'b1; wdata = d[i];
      @(negedge clk);
      for (int k = 0; k < n_duts(); k++) if (!wr[k]) wr_low[k]++;
      @(posedge clk); #1;
      if (i == stall_after) begin
        for (int s = 0; s < stall_n; s++) begin
          wvalid = 1'b0; wdata = 32'hBAD0_0000;
          @(negedge clk);
          for (int k = 0; k < n_duts(); k++) if (!wr[k]) wr_low[k]++;
          @(posedge clk); #1;
        end
      end
    end
    wvalid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < n_duts(); k++) begin
      chk($sformatf("%s dut%0d done", tag, k), 32'(dn[k]), 32'd1);
      chk($sformatf("%s dut%0d wready_drop", tag, k), 32'(wr[k]), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < n_duts(); k++) begin
      chk($sformatf("%s dut%0d busy_after", tag, k), 32'(bz[k]), 32'd0);
      chk($sformatf("%s dut%0d done_single", tag, k), 32'(dn[k]), 32'd0);
      chk($sformatf("%s dut%0d wready_low_cycles", tag, k), 32'(wr_low[k]), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_read(input logic [31:0] a, input logic [7:0] l, input logic [31:0] exp [8],
                          input string tag);
    int   first_k [3] = '{0, 0, 0};
    int   last_k  [3] = '{0, 0, 0};
    int   nb      [3] = '{0, 0, 0};
    int   nd      [3] = '{0, 0, 0};
    int   done_k  [3] = '{0, 0, 0};
    logic b_in    [3] = '{1'b0, 1'b0, 1'b0};
    logic b_out   [3] = '{1'b1, 1'b1, 1'b1};
    start = 1'b1; rw = 1'b1; addr = a; len = l;
    @(posedge clk); #1;
    start = 1'b0; rw = 1'b0; addr = 32'hFFFF_FFFC; len = 8'hFF;
    for (int k = 1; k <= int'(l) + 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < n_duts(); d++) begin
        if (rv[d]) begin
          if (nb[d] == 0) first_k[d] = k;
          last_k[d] = k;
          if (nb[d] <= int'(l))
            chk($sformatf("%s dut%0d beat%0d", tag, d, nb[d]), rd[d], exp[nb[d]]);
          nb[d]++;
        end
        if (dn[d]) begin
          nd[d]++;
          done_k[d] = k;
        end
        if (k == 2 + lat_of(d) + int'(l)) b_in[d]  = bz[d];
        if (k == 3 + lat_of(d) + int'(l)) b_out[d] = bz[d];
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < n_duts(); d++) begin
      chk($sformatf("%s dut%0d first_rvalid", tag, d), 32'(first_k[d]), 32'(1 + lat_of(d)));
      chk($sformatf("%s dut%0d last_rvalid", tag, d), 32'(last_k[d]), 32'(1 + lat_of(d) + int'(l)));
      chk($sformatf("%s dut%0d beats", tag, d), 32'(nb[d]), 32'(int'(l) + 1));
      chk($sformatf("%s dut%0d done_count", tag, d), 32'(nd[d]), 32'd1);
      chk($sformatf("%s dut%0d done_cycle", tag, d), 32'(done_k[d]), 32'(2 + lat_of(d) + int'(l)));
      chk($sformatf("%s dut%0d busy_in_done", tag, d), 32'(b_in[d]), 32'd1);
      chk($sformatf("%s dut%0d busy_after", tag, d), 32'(b_out[d]), 32'd0);
    end
  endtask

  logic [31:0] dv [8];
  int          nb_i;
  int          dn_i;

  initial begin
    resetn = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; len = '0;
    wdata = '0; wvalid = 1'b0; all_en = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset dut%0d wready", d), 32'(wr[d]), 32'd0);
      chk($sformatf("reset dut%0d rvalid", d), 32'(rv[d]), 32'd0);
      chk($sformatf("reset dut%0d rdata", d), rd[d], 32'd0);
      chk($sformatf("reset dut%0d done", d), 32'(dn[d]), 32'd0);
      chk($sformatf("reset dut%0d busy", d), 32'(bz[d]), 32'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Words: 0x40 <- DEADBEEF; 0x100.. <- 0x11*(i+1); 1022,1023,0,1 <- C0..C3; 2,3 <- C4,C5.
    vecs[0] = '{1'b0, 32'h40,  8'd0, -1, 0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 32'h40,  8'd0, -1, 0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 32'h100, 8'd7,  3, 2, 32'h11,       32'h11};
    vecs[3] = '{1'b1, 32'h100, 8'd7, -1, 0, 32'h11,       32'h11};
    vecs[4] = '{1'b0, 32'hFF8, 8'd3, -1, 0, 32'hC0,       32'h1};
    vecs[5] = '{1'b0, 32'h8,   8'd1, -1, 0, 32'hC4,       32'h1};
    vecs[6] = '{1'b1, 32'h0,   8'd3, -1, 0, 32'hC2,       32'h1};
    vecs[7] = '{1'b1, 32'hFF8, 8'd3, -1, 0, 32'hC0,       32'h1};

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 8; i++) dv[i] = vecs[v].base + 32'(i) * vecs[v].step;
      if (vecs[v].rw)
        run_read(vecs[v].addr, vecs[v].len, dv, $sformatf("vec%0d", v));
      else
        run_write(vecs[v].addr, vecs[v].len, dv, vecs[v].stall_after, vecs[v].stall_n,
                  $sformatf("vec%0d", v));
    end

    // Starts during the burst and in the DONE cycle must be dropped.
    all_en = 1'b0;
    nb_i = 0; dn_i = 0;
    start = 1'b1; rw = 1'b1; addr = 32'h100; len = 8'd7;
    @(posedge clk); #1;
    for (int k = 1; k <= 11; k++) begin
      start = (k == 5 || k == 11); rw = 1'b1; addr = 32'h40; len = 8'd0;
      @(negedge clk);
      if (rv[0]) begin
        if (nb_i < 8) chk($sformatf("ign beat%0d", nb_i), rd[0], 32'h11 * 32'(nb_i + 1));
        nb_i++;
      end
      if (dn[0]) dn_i++;
      @(posedge clk); #1;
    end
    chk("ign beats", 32'(nb_i), 32'd8);
    chk("ign done_count", 32'(dn_i), 32'd1);
    start = 1'b1; rw = 1'b1; addr = 32'h40; len = 8'd0;
    @(negedge clk);
    chk("ign idle_before_restart", 32'(bz[0]), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    nb_i = 0; dn_i = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("ign restart_busy", 32'(bz[0]), 32'd1);
      if (rv[0]) begin
        chk("ign restart_data", rd[0], 32'hDEADBEEF);
        chk("ign restart_cycle", 32'(k), 32'd3);
        nb_i++;
      end
      if (dn[0]) dn_i++;
      @(posedge clk); #1;
    end
    chk("ign restart_beats", 32'(nb_i), 32'd1);
    chk("ign restart_done", 32'(dn_i), 32'd1);
    all_en = 1'b1;

    // Reset lands mid-cycle after beat 2 of an 8-beat write over 0x100.
    start = 1'b1; rw = 1'b0; addr = 32'h100; len = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1; wdata = 32'hF1 + 32'(i);
      @(posedge clk); #1;
    end
    wvalid = 1'b1; wdata = 32'hF4;
    #1 resetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("arst dut%0d busy", d), 32'(bz[d]), 32'd0);
      chk($sformatf("arst dut%0d wready", d), 32'(wr[d]), 32'd0);
      chk($sformatf("arst dut%0d done", d), 32'(dn[d]), 32'd0);
      chk($sformatf("arst dut%0d rvalid", d), 32'(rv[d]), 32'd0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    dv[0] = 32'hF1; dv[1] = 32'hF2; dv[2] = 32'hF3; dv[3] = 32'h44;
    dv[4] = 32'h55; dv[5] = 32'h66; dv[6] = 32'h77; dv[7] = 32'h88;
    run_read(32'h100, 8'd7, dv, "arst_read");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
